draw_sprite: RTL and testbench
==============================

// Module: draw_sprite
// PURPOSE
//  Parametrised sprite renderer for the VGA pipeline. Replaces fixed-position,
//  fixed-size block drawers: sprite origin, palette, flip and enable are run-time
//  inputs; size, scale and ROM latency are parameters. Reads a 2-bit/pixel
//  external sprite ROM and emits an 8-bit pixel plus a valid flag for the mixer.
// PARAMETERS
//  SPR_W       78  sprite width in ROM texels (>=1)
//  SPR_H       53  sprite height in ROM texels (>=1)
//  SCALE_LOG2  0   on-screen texel size = 2**SCALE_LOG2 pixels each axis (0..3)
//  ROM_LAT     1   cycles from mem_addr change to mem_data valid (1..4)
//  ADDR_W      13  ROM address width; must satisfy 2**ADDR_W >= SPR_W*SPR_H
// PORTS
//  vclk       in   1       pixel clock; all logic on rising edge
//  rst        in   1       synchronous reset, active-low (0 = reset)
//  hcount     in   11      current horizontal pixel counter
//  vcount     in   10      current vertical line counter
//  org_x      in   11      sprite left edge, screen pixels
//  org_y      in   10      sprite top edge, screen lines
//  enable     in   1       draw sprite when 1
//  hflip      in   1       mirror sprite horizontally when 1
//  pal1       in   8       colour for texel index 2'b01
//  pal2       in   8       colour for texel index 2'b10
//  pal3       in   8       colour for texel index 2'b11
//  mem_addr   out  ADDR_W  ROM address (registered)
//  mem_data   in   2       ROM texel index, valid ROM_LAT cycles after mem_addr
//  pixel_out  out  8       colour to mixer
//  pixel_vld  out  1       1 = sprite opaque at this pixel; mixer uses pixel_out
// BEHAVIOUR
//  - Reset (rst==0 at edge): mem_addr=0, pixel_out=8'h00, pixel_vld=0, latched
//    origin/flip/enable=0, all pipeline valid bits cleared. Reset mid-frame: no
//    output until next frame latch; no partial-sprite glitch.
//  - Frame latch: on the cycle hcount==0 && vcount==0, register org_x, org_y,
//    hflip, enable. Changes at other times are ignored until the next latch
//    (no tearing). All hit tests below use latched values.
//  - Stage 0 (registered): dx=hcount-ox, dy=vcount-oy computed 12-bit unsigned
//    with extension (no wrap). hit = en_l && hcount>=ox && vcount>=oy &&
//    dx < SPR_W<<SCALE_LOG2 && dy < SPR_H<<SCALE_LOG2.
//    col=dx>>SCALE_LOG2; if flip_l col=SPR_W-1-col; row=dy>>SCALE_LOG2.
//    mem_addr <= hit ? row*SPR_W+col : 0 (ADDR_W bits, no overflow by param rule).
//  - hit bit delayed ROM_LAT cycles in a shift register aligned with mem_data.
//  - Stage out (registered): if delayed hit && mem_data!=0: pixel_vld<=1,
//    pixel_out<=pal1/pal2/pal3 per index; else pixel_vld<=0, pixel_out<=8'h00.
//    Index 2'b00 is transparent.
//  - Latency: hcount/vcount sample -> pixel_out/pixel_vld = ROM_LAT+2 cycles,
//    fixed; upstream delays hcount-based sync accordingly.
//  - Address is computed from coordinates, never from a running counter:
//    blanking, hcount outside sprite, or partial off-screen origin cannot
//    desynchronise rows. Sprite extending past visible area is clipped naturally.
//  - enable low at latch: hit=0 for whole frame; in-flight pipeline drains
//    normally (at most ROM_LAT+2 stale-free cycles, all vld=0 after drain).
//  - org_x/org_y near counter max: comparisons in 12 bits; no wrap to left/top.
// TESTING
//  1 Reset: rst=0 3 cycles mid-sprite -> pixel_vld=0, pixel_out=0, mem_addr=0.
//  2 SPR_W=78,SPR_H=53,org=(286,407), ROM=address-pattern: at (286,407) addr=0;
//    (363,407) addr=77; (286,408) addr=78; (363,459) addr=4133; vld at
//    ROM_LAT+2 cycles after sample; (285,407),(364,407),(300,460) vld=0.
//  3 Palette/transparency: texels 0,1,2,3 with pal1=F0,pal2=1C,pal3=FF ->
//    vld 0,1,1,1; pixel_out 00,F0,1C,FF.
//  4 hflip=1, SCALE_LOG2=1: at dx=0 addr=row*78+77; dx=1 same addr; dx=2 addr-1;
//    sprite spans 156x106 pixels.
//  5 Change org_x mid-frame to 100 -> current frame unchanged; next frame
//    first opaque pixel at hcount=100. enable=0 at latch -> vld=0 whole frame.
//  6 ROM_LAT=3 regression of scenario 2: identical values, latency 5 cycles.

Source files
------------

// File: rtl/draw_sprite.sv
// Draws a 2-bit/pixel ROM sprite at a per-frame latched origin, with palette lookup, h-flip and integer scaling.
// Latency ROM_LAT+2 cycles from hcount/vcount to pixel_out/pixel_vld; free-running, no backpressure.
module draw_sprite #(
    parameter int SPR_W      = 78,
    parameter int SPR_H      = 53,
    parameter int SCALE_LOG2 = 0,
    parameter int ROM_LAT    = 1,
    parameter int ADDR_W     = 13
) (
    input  logic              vclk,
    input  logic              rst,
    input  logic [10:0]       hcount,
    input  logic [9:0]        vcount,
    input  logic [10:0]       org_x,
    input  logic [9:0]        org_y,
    input  logic              enable,
    input  logic              hflip,
    input  logic [7:0]        pal1,
    input  logic [7:0]        pal2,
    input  logic [7:0]        pal3,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [1:0]        mem_data,
    output logic [7:0]        pixel_out,
    output logic              pixel_vld
);
    localparam int EXT_W = SPR_W << SCALE_LOG2;
    localparam int EXT_H = SPR_H << SCALE_LOG2;

    logic [10:0]       ox_q;
    logic [9:0]        oy_q;
    logic              flip_q;
    logic              en_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [ADDR_W-1:0] addr_d;
    // bit 0 lines up with mem_addr_q, bit ROM_LAT with mem_data
    logic [ROM_LAT:0]  hit_q;
    logic [7:0]        pix_q;
    logic [7:0]        pix_d;
    logic              vld_q;
    logic              vld_d;
    logic [11:0]       dx;
    logic [11:0]       dy;
    logic [11:0]       col;
    logic [11:0]       row;
    logic              hit_d;

    // 12-bit differences so origins near the counter maximum never wrap onto the left/top edge
    always_comb begin
        dx     = {1'b0, hcount} - {1'b0, ox_q};
        dy     = {2'b00, vcount} - {2'b00, oy_q};
        hit_d  = en_q && (hcount >= ox_q) && (vcount >= oy_q)
                 && ({20'd0, dx} < 32'(EXT_W)) && ({20'd0, dy} < 32'(EXT_H));
        col    = dx >> SCALE_LOG2;
        if (flip_q) begin
            col = 12'(SPR_W - 1) - col;
        end
        row    = dy >> SCALE_LOG2;
        addr_d = ADDR_W'(row) * ADDR_W'(SPR_W) + ADDR_W'(col);
    end

    always_comb begin
        vld_d = 1'b0;
        pix_d = 8'h00;
        if (hit_q[ROM_LAT]) begin
            case (mem_data)
                2'b01:   begin vld_d = 1'b1; pix_d = pal1; end
                2'b10:   begin vld_d = 1'b1; pix_d = pal2; end
                2'b11:   begin vld_d = 1'b1; pix_d = pal3; end
                default: begin vld_d = 1'b0; pix_d = 8'h00; end
            endcase
        end
    end

    always_ff @(posedge vclk) begin
        if (!rst) begin
            ox_q       <= '0;
            oy_q       <= '0;
            flip_q     <= 1'b0;
            en_q       <= 1'b0;
            mem_addr_q <= '0;
            hit_q      <= '0;
            vld_q      <= 1'b0;
            pix_q      <= 8'h00;
        end else begin
            if (hcount == '0 && vcount == '0) begin
                ox_q   <= org_x;
                oy_q   <= org_y;
                flip_q <= hflip;
                en_q   <= enable;
            end
            mem_addr_q <= hit_d ? addr_d : '0;
            hit_q      <= {hit_q[ROM_LAT-1:0], hit_d};
            vld_q      <= vld_d;
            pix_q      <= pix_d;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign pixel_out = pix_q;
    assign pixel_vld = vld_q;
endmodule

// File: tb/tb_draw_sprite.sv
// Bench for draw_sprite: three instances (base, 2x scale, ROM_LAT=3) against a coordinate-level reference model.
module tb_draw_sprite;
    localparam int W    = 78;
    localparam int H    = 53;
    localparam int NDUT = 3;

    logic        vclk = 1'b0;
    logic        rst;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic [10:0] org_x;
    logic [9:0]  org_y;
    logic        enable;
    logic        hflip;
    logic [7:0]  pal1;
    logic [7:0]  pal2;
    logic [7:0]  pal3;
    logic [12:0] mem_addr0, mem_addr1, mem_addr2;
    logic [1:0]  mem_data0, mem_data1, mem_data2;
    logic [7:0]  pix0, pix1, pix2;
    logic        vld0, vld1, vld2;

    logic [1:0]  rom [8192];
    logic [1:0]  rp0 = 2'b00;
    logic [1:0]  rp1 = 2'b00;
    logic [1:0]  rp2 [3] = '{2'b00, 2'b00, 2'b00};

    int vectors = 0;
    int miscompares = 0;

    int m_ox, m_oy;
    bit m_en, m_fl;
    int exq [NDUT][$];

    always #5 vclk = ~vclk;

    draw_sprite #(.SPR_W(W), .SPR_H(H), .SCALE_LOG2(0), .ROM_LAT(1), .ADDR_W(13)) u0 (
        .vclk(vclk), .rst(rst), .hcount(hcount), .vcount(vcount), .org_x(org_x), .org_y(org_y),
        .enable(enable), .hflip(hflip), .pal1(pal1), .pal2(pal2), .pal3(pal3),
        .mem_addr(mem_addr0), .mem_data(mem_data0), .pixel_out(pix0), .pixel_vld(vld0));
    draw_sprite #(.SPR_W(W), .SPR_H(H), .SCALE_LOG2(1), .ROM_LAT(1), .ADDR_W(13)) u1 (
        .vclk(vclk), .rst(rst), .hcount(hcount), .vcount(vcount), .org_x(org_x), .org_y(org_y),
        .enable(enable), .hflip(hflip), .pal1(pal1), .pal2(pal2), .pal3(pal3),
        .mem_addr(mem_addr1), .mem_data(mem_data1), .pixel_out(pix1), .pixel_vld(vld1));
    draw_sprite #(.SPR_W(W), .SPR_H(H), .SCALE_LOG2(0), .ROM_LAT(3), .ADDR_W(13)) u2 (
        .vclk(vclk), .rst(rst), .hcount(hcount), .vcount(vcount), .org_x(org_x), .org_y(org_y),
        .enable(enable), .hflip(hflip), .pal1(pal1), .pal2(pal2), .pal3(pal3),
        .mem_addr(mem_addr2), .mem_data(mem_data2), .pixel_out(pix2), .pixel_vld(vld2));

    // external ROM with 1 or 3 cycles of read latency
    always @(posedge vclk) begin
        rp0    <= rom[mem_addr0];
        rp1    <= rom[mem_addr1];
        rp2[0] <= rom[mem_addr2];
        rp2[1] <= rp2[0];
        rp2[2] <= rp2[1];
    end
    assign mem_data0 = rp0;
    assign mem_data1 = rp1;
    assign mem_data2 = rp2[2];

    function automatic int scale_of(int d);
        return (d == 1) ? 2 : 1;
    endfunction

    function automatic int lat_of(int d);
        return (d == 2) ? 3 : 1;
    endfunction

    function automatic logic [12:0] dut_addr(int d);
        case (d)
            0:       return mem_addr0;
            1:       return mem_addr1;
            default: return mem_addr2;
        endcase
    endfunction

    function automatic logic dut_vld(int d);
        case (d)
            0:       return vld0;
            1:       return vld1;
            default: return vld2;
        endcase
    endfunction

    function automatic logic [7:0] dut_pix(int d);
        case (d)
            0:       return pix0;
            1:       return pix1;
            default: return pix2;
        endcase
    endfunction

    function automatic logic [7:0] colour(int idx);
        case (idx)
            1:       return pal1;
            2:       return pal2;
            3:       return pal3;
            default: return 8'h00;
        endcase
    endfunction

    // Sprite covers W*s by H*s screen pixels from the latched origin; each texel is s x s pixels.
    function automatic int model_addr(int d, int hc, int vc, output bit hit);
        int s, dx, dy, col, row;
        s   = scale_of(d);
        hit = 1'b0;
        if (!m_en || hc < m_ox || vc < m_oy) return 0;
        dx = hc - m_ox;
        dy = vc - m_oy;
        if (dx >= W * s || dy >= H * s) return 0;
        col = dx / s;
        if (m_fl) col = W - 1 - col;
        row = dy / s;
        hit = 1'b1;
        return row * W + col;
    endfunction

    // One pixel clock: present (hc,vc), predict, clock, then score all three instances.
    task automatic step(input int hc, input int vc);
        int  ea [NDUT];
        bit  eh [NDUT];
        int  widx;
        logic [7:0] wpix;
        hcount = 11'(hc);
        vcount = 10'(vc);
        for (int d = 0; d < NDUT; d++) begin
            if (!rst) begin
                ea[d] = 0;
                eh[d] = 1'b0;
            end else begin
                ea[d] = model_addr(d, hc, vc, eh[d]);
            end
        end
        if (!rst) begin
            m_ox = 0; m_oy = 0; m_en = 1'b0; m_fl = 1'b0;
            for (int d = 0; d < NDUT; d++) begin
                exq[d].delete();
                repeat (lat_of(d) + 1) exq[d].push_back(0);
            end
        end else if (hc == 0 && vc == 0) begin
            m_ox = int'(org_x); m_oy = int'(org_y); m_en = enable; m_fl = hflip;
        end
        for (int d = 0; d < NDUT; d++) exq[d].push_back(eh[d] ? int'(rom[ea[d]]) : 0);
        @(posedge vclk);
        #1;
        for (int d = 0; d < NDUT; d++) begin
            vectors++;
            if (dut_addr(d) !== 13'(ea[d])) begin
                miscompares++;
                $display("FAIL mem_addr dut%0d t=%0t got %0d want %0d", d, $time, dut_addr(d), ea[d]);
            end
            widx = exq[d].pop_front();
            wpix = colour(widx);
            vectors++;
            if (dut_vld(d) !== (widx != 0) || dut_pix(d) !== wpix) begin
                miscompares++;
                $display("FAIL pixel dut%0d t=%0t got vld=%b pix=%h want vld=%b pix=%h",
                         d, $time, dut_vld(d), dut_pix(d), widx != 0, wpix);
            end
        end
    endtask

    task automatic drain();
        repeat (6) step(2000, 1000);
    endtask

    task automatic test_reset();
        rst = 1'b0; enable = 1'b1; hflip = 1'b0; org_x = 11'd286; org_y = 10'd407;
        pal1 = 8'hF0; pal2 = 8'h1C; pal3 = 8'hFF;
        repeat (3) step(0, 0);
        rst = 1'b1;
        step(0, 0);
        for (int i = 0; i < 4; i++) step(300 + i, 410);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(304 + i, 410);
            vectors++;
            if (vld0 !== 1'b0 || pix0 !== 8'h00 || mem_addr0 !== 13'd0) begin
                miscompares++;
                $display("FAIL reset_outputs got vld=%b pix=%h addr=%0d want 0/00/0", vld0, pix0, mem_addr0);
            end
        end
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(310 + i, 410);
            vectors++;
            if (vld0 !== 1'b0 || vld2 !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_no_draw got vld0=%b vld2=%b want 0", vld0, vld2);
            end
        end
    endtask

    task automatic test_address();
        int pts [7][3] = '{'{286, 407, 0}, '{363, 407, 77}, '{286, 408, 78}, '{363, 459, 4133},
                           '{285, 407, 0}, '{364, 407, 0}, '{300, 460, 0}};
        int first0, first2;
        org_x = 11'd286; org_y = 10'd407; enable = 1'b1; hflip = 1'b0;
        step(0, 0);
        for (int i = 0; i < 7; i++) begin
            step(pts[i][0], pts[i][1]);
            vectors++;
            if (mem_addr0 !== 13'(pts[i][2]) || mem_addr2 !== 13'(pts[i][2])) begin
                miscompares++;
                $display("FAIL addr_point (%0d,%0d) got %0d/%0d want %0d",
                         pts[i][0], pts[i][1], mem_addr0, mem_addr2, pts[i][2]);
            end
        end
        drain();
        rom[4133] = 2'b11;
        first0 = 0; first2 = 0;
        step(363, 459);
        for (int n = 2; n <= 7; n++) begin
            step(2000, 1000);
            if (vld0 && first0 == 0) first0 = n;
            if (vld2 && first2 == 0) first2 = n;
        end
        vectors++;
        if (first0 != 3 || first2 != 5) begin
            miscompares++;
            $display("FAIL latency got %0d/%0d want 3/5", first0, first2);
        end
    endtask

    task automatic test_palette();
        logic       ev [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        logic [7:0] ep [4] = '{8'h00, 8'hF0, 8'h1C, 8'hFF};
        drain();
        for (int i = 0; i < 4; i++) rom[i] = 2'(i);
        pal1 = 8'hF0; pal2 = 8'h1C; pal3 = 8'hFF;
        for (int j = 0; j < 6; j++) begin
            step((j < 4) ? 286 + j : 2000, (j < 4) ? 407 : 1000);
            if (j >= 2) begin
                vectors++;
                if (vld0 !== ev[j - 2] || pix0 !== ep[j - 2]) begin
                    miscompares++;
                    $display("FAIL palette texel%0d got vld=%b pix=%h want vld=%b pix=%h",
                             j - 2, vld0, pix0, ev[j - 2], ep[j - 2]);
                end
            end
        end
    endtask

    task automatic test_flip_scale();
        int pts [6][3] = '{'{286, 407, 77}, '{287, 407, 77}, '{288, 407, 76},
                           '{441, 512, 4056}, '{442, 512, 0}, '{441, 513, 0}};
        drain();
        hflip = 1'b1;
        step(0, 0);
        for (int i = 0; i < 6; i++) begin
            step(pts[i][0], pts[i][1]);
            vectors++;
            if (mem_addr1 !== 13'(pts[i][2])) begin
                miscompares++;
                $display("FAIL flip_scale (%0d,%0d) got %0d want %0d",
                         pts[i][0], pts[i][1], mem_addr1, pts[i][2]);
            end
        end
        drain();
        hflip = 1'b0;
    endtask

    task automatic test_latch();
        int first, cnt;
        step(0, 0);
        org_x = 11'd100;
        step(100, 407);
        vectors++;
        if (mem_addr0 !== 13'd0) begin
            miscompares++;
            $display("FAIL no_tearing got addr=%0d want 0", mem_addr0);
        end
        for (int i = 0; i < 20; i++) step(101 + i, 407);
        drain();
        step(0, 0);
        rom[0] = 2'b10;
        first = -1;
        for (int j = 0; j < 13; j++) begin
            step(95 + j, 407);
            if (vld0 && first < 0) first = 95 + j - 2;
        end
        vectors++;
        if (first != 100) begin
            miscompares++;
            $display("FAIL next_frame_origin got first=%0d want 100", first);
        end
        drain();
        enable = 1'b0;
        step(0, 0);
        enable = 1'b1;
        cnt = 0;
        for (int i = 0; i < 200; i++) begin
            step(90 + i, 407 + (i % 40));
            cnt += int'(vld0) + int'(vld1) + int'(vld2);
        end
        vectors++;
        if (cnt != 0) begin
            miscompares++;
            $display("FAIL enable_off got %0d opaque pixels want 0", cnt);
        end
    endtask

    task automatic test_random();
        int cx, cy, hc, vc;
        cx = 100; cy = 407;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                rst = 1'b0;
                step($urandom_range(0, 2047), $urandom_range(0, 1023));
                rst = 1'b1;
            end
            if ($urandom_range(0, 149) == 0) begin
                if ($urandom_range(0, 3) == 0) begin
                    org_x = 11'($urandom_range(1990, 2047));
                    org_y = 10'($urandom_range(960, 1023));
                end else begin
                    org_x = 11'($urandom_range(0, 2047));
                    org_y = 10'($urandom_range(0, 1023));
                end
                enable = ($urandom_range(0, 3) != 0);
                hflip  = 1'($urandom);
                cx = int'(org_x); cy = int'(org_y);
                step(0, 0);
            end
            if ($urandom_range(0, 9) == 0) begin
                org_x = 11'($urandom);
                org_y = 10'($urandom);
                hflip = 1'($urandom);
            end
            if ($urandom_range(0, 7) == 0) begin
                pal1 = 8'($urandom); pal2 = 8'($urandom); pal3 = 8'($urandom);
            end
            hc = (cx + $urandom_range(0, 2 * W + 20) - 10) & 2047;
            vc = (cy + $urandom_range(0, 2 * H + 20) - 10) & 1023;
            step(hc, vc);
        end
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) rom[i] = 2'($urandom);
        rst = 1'b0; hcount = '0; vcount = '0; org_x = '0; org_y = '0;
        enable = 1'b0; hflip = 1'b0; pal1 = '0; pal2 = '0; pal3 = '0;
        test_reset();
        test_address();
        test_palette();
        test_flip_scale();
        test_latch();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
